// File: rtl/ex_mdu_stage_pkg.sv
// Shared opcodes, memory-op codes and FSM encodings for the execute/MDU stage.
// Build option: EX_MDU_DIV_EN enables the iterative divider.
package ex_mdu_stage_pkg;

  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_JAL_OP   = 8'b0101_0000;
  localparam logic [7:0] EXE_LB_OP    = 8'b1110_0000;
  localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP    = 8'b1110_1000;
  localparam logic [7:0] EXE_SW_OP    = 8'b1110_1011;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_MULH_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MULHU_OP = 8'b1010_1011;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MOD_OP   = 8'b0001_1100;
  localparam logic [7:0] EXE_MODU_OP  = 8'b0001_1101;

  localparam logic [7:0] MEM_NOP_OP = 8'h00;
  localparam logic [7:0] MEM_LB_OP  = 8'h01;
  localparam logic [7:0] MEM_LW_OP  = 8'h02;
  localparam logic [7:0] MEM_SB_OP  = 8'h03;
  localparam logic [7:0] MEM_SW_OP  = 8'h04;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {
    EX_STATE_IDLE = 2'b00,
    EX_STATE_MUL  = 2'b01,
    EX_STATE_DIV  = 2'b10,
    EX_STATE_DONE = 2'b11
  } ex_state_e;

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == EXE_MUL_OP) || (op == EXE_MULH_OP) || (op == EXE_MULHU_OP);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
           (op == EXE_MOD_OP) || (op == EXE_MODU_OP);
  endfunction

endpackage

// File: rtl/ex_mdu_stage_divider.sv
// Iterative restoring divider on magnitudes; signs and the divide-by-zero case
// are fixed up on the registered result. Used only when EX_MDU_DIV_EN is defined.
module ex_divider #(
  parameter int XLEN    = 32,
  parameter int RADIX_B = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int ITER  = XLEN / RADIX_B;
  localparam int CNT_W = $clog2(ITER + 1);

  logic [XLEN-1:0]  quo_q, rem_q, div_q, dividend_q;
  logic             q_neg_q, r_neg_q, zero_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    r_step;
  logic [XLEN-1:0]  q_step;
  logic             a_neg, b_neg;

  assign a_neg = signed_op & dividend[XLEN-1];
  assign b_neg = signed_op & divisor[XLEN-1];

  // RADIX_B shift-compare-subtract steps per clock
  always_comb begin
    r_step = {1'b0, rem_q};
    q_step = quo_q;
    for (int i = 0; i < RADIX_B; i++) begin
      r_step = {r_step[XLEN-1:0], q_step[XLEN-1]};
      q_step = {q_step[XLEN-2:0], 1'b0};
      if (r_step >= {1'b0, div_q}) begin
        r_step    = r_step - {1'b0, div_q};
        q_step[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      dividend_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      zero_q     <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      quo_q      <= a_neg ? -dividend : dividend;
      div_q      <= b_neg ? -divisor : divisor;
      rem_q      <= '0;
      dividend_q <= dividend;
      q_neg_q    <= a_neg ^ b_neg;
      r_neg_q    <= a_neg;
      zero_q     <= (divisor == '0);
      cnt        <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (busy) begin
      quo_q <= q_step;
      rem_q <= r_step[XLEN-1:0];
      cnt   <= cnt + 1'b1;
      if (cnt == CNT_W'(ITER - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quotient  = zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
  assign remainder = zero_q ? dividend_q : (r_neg_q ? -rem_q : rem_q);

endmodule

// File: rtl/ex_mdu_stage.sv
// Registered execute stage: single-cycle ALU, MUL_LAT-deep multiplier pipe and,
// when EX_MDU_DIV_EN is defined, an iterative divider; stalls upstream while busy.
module ex_mdu_stage
  import ex_mdu_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int RADIX_B = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [7:0]      aluop_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      waddr_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] link_addr_i,
  input  logic [31:0]     inst_i,
  output logic            stallreq_o,
  output logic            valid_o,
  output logic [4:0]      waddr_o,
  output logic            we_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [7:0]      aluop_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_data_o,
  output ex_state_e       fsm_state
);
  localparam int DIV_ITER = XLEN / RADIX_B;
  localparam int CNT_W    = $clog2(DIV_ITER + MUL_LAT + 1);

  ex_state_e        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept, acc_mul, acc_div, acc_single;
  logic [7:0]       op_q;
  logic [4:0]       waddr_q;
  logic             we_q;
  logic [XLEN-1:0]  alu_result, mem_addr_d, mem_data_d, mdu_result;
  logic [7:0]       mem_op_d;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [2*XLEN-1:0] mul_pipe [MUL_LAT];

  // Handshake: the stage takes an instruction when valid_i & ~stallreq_o & ~flush_i;
  // while stallreq_o is high the upstream register must hold its outputs.
  assign accept  = valid_i & ~stallreq_o & ~flush_i;
  assign acc_mul = accept & is_mul_op(aluop_i);
`ifdef EX_MDU_DIV_EN
  assign acc_div = accept & is_div_op(aluop_i);
`else
  assign acc_div = 1'b0;
`endif
  assign acc_single = accept & ~acc_mul & ~acc_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EX_STATE_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next == state) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = EX_STATE_IDLE;
    end else begin
      case (state)
        EX_STATE_IDLE: begin
          if (acc_mul)      state_next = (MUL_LAT == 1) ? EX_STATE_DONE : EX_STATE_MUL;
          else if (acc_div) state_next = EX_STATE_DIV;
        end
        EX_STATE_MUL:  if (cnt == CNT_W'(MUL_LAT - 2))  state_next = EX_STATE_DONE;
        EX_STATE_DIV:  if (cnt == CNT_W'(DIV_ITER - 1)) state_next = EX_STATE_DONE;
        EX_STATE_DONE: state_next = EX_STATE_IDLE;
        default:       state_next = EX_STATE_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = (state != EX_STATE_IDLE);
    fsm_state  = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      waddr_q <= NOP_REG_ADDR;
      we_q    <= 1'b0;
    end else if (acc_mul | acc_div) begin
      op_q    <= aluop_i;
      waddr_q <= waddr_i;
      we_q    <= we_i;
    end
  end

  // Operands are sign-extended only for MULH; the low word is sign-agnostic
  assign mul_a   = {{XLEN{(aluop_i == EXE_MULH_OP) & reg1_i[XLEN-1]}}, reg1_i};
  assign mul_b   = {{XLEN{(aluop_i == EXE_MULH_OP) & reg2_i[XLEN-1]}}, reg2_i};
  assign product = mul_a * mul_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
    end else begin
      mul_pipe[0] <= product;
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

`ifdef EX_MDU_DIV_EN
  logic [XLEN-1:0] div_quo, div_rem;
  logic            div_busy, div_done;

  ex_divider #(.XLEN(XLEN), .RADIX_B(RADIX_B)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (acc_div),
    .abort     (flush_i),
    .signed_op ((aluop_i == EXE_DIV_OP) || (aluop_i == EXE_MOD_OP)),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_comb begin
    mdu_result = '0;
    if (op_q == EXE_MUL_OP)                                mdu_result = mul_pipe[MUL_LAT-1][XLEN-1:0];
    else if (op_q == EXE_MULH_OP || op_q == EXE_MULHU_OP)  mdu_result = mul_pipe[MUL_LAT-1][2*XLEN-1:XLEN];
`ifdef EX_MDU_DIV_EN
    else if (op_q == EXE_DIV_OP || op_q == EXE_DIVU_OP)    mdu_result = div_quo;
    else if (op_q == EXE_MOD_OP || op_q == EXE_MODU_OP)    mdu_result = div_rem;
`endif
  end

  assign mem_addr_d = reg1_i + {{(XLEN-16){inst_i[15]}}, inst_i[15:0]};

  always_comb begin
    alu_result = '0;
    mem_op_d   = MEM_NOP_OP;
    mem_data_d = '0;
    case (aluop_i)
      EXE_AND_OP:  alu_result = reg1_i & reg2_i;
      EXE_OR_OP:   alu_result = reg1_i | reg2_i;
      EXE_XOR_OP:  alu_result = reg1_i ^ reg2_i;
      EXE_NOR_OP:  alu_result = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  alu_result = reg2_i << reg1_i[4:0];
      EXE_SRL_OP:  alu_result = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP:  alu_result = $signed(reg2_i) >>> reg1_i[4:0];
      EXE_SLT_OP:  alu_result = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: alu_result = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
      EXE_ADD_OP:  alu_result = reg1_i + reg2_i;
      EXE_SUB_OP:  alu_result = reg1_i - reg2_i;
      EXE_JAL_OP:  alu_result = link_addr_i;
      EXE_LB_OP:   mem_op_d = MEM_LB_OP;
      EXE_LW_OP:   mem_op_d = MEM_LW_OP;
      EXE_SB_OP: begin
        mem_op_d   = MEM_SB_OP;
        mem_data_d = reg2_i;
      end
      EXE_SW_OP: begin
        mem_op_d   = MEM_SW_OP;
        mem_data_d = reg2_i;
      end
      default:     alu_result = '0;
    endcase
  end

  // valid_o/we_o are one-shot so MEM/WB never see a result twice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o    <= 1'b0;
      waddr_o    <= NOP_REG_ADDR;
      we_o       <= 1'b0;
      wdata_o    <= '0;
      aluop_o    <= MEM_NOP_OP;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      we_o    <= 1'b0;
      aluop_o <= MEM_NOP_OP;
    end else if (state == EX_STATE_DONE) begin
      valid_o    <= 1'b1;
      waddr_o    <= waddr_q;
      we_o       <= we_q;
      wdata_o    <= mdu_result;
      aluop_o    <= MEM_NOP_OP;
      mem_data_o <= '0;
    end else if (acc_single) begin
      valid_o    <= 1'b1;
      waddr_o    <= waddr_i;
      we_o       <= we_i;
      wdata_o    <= alu_result;
      aluop_o    <= mem_op_d;
      mem_addr_o <= mem_addr_d;
      mem_data_o <= mem_data_d;
    end else begin
      valid_o <= 1'b0;
      we_o    <= 1'b0;
      aluop_o <= MEM_NOP_OP;
    end
  end

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed self-checking bench for ex_mdu_stage; divider vectors are used
// when EX_MDU_DIV_EN is defined, the no-divider behaviour otherwise.
module tb_ex_mdu_stage;
  import ex_mdu_stage_pkg::*;

  localparam int XLEN_TB    = 32;
  localparam int MUL_LAT_TB = 3;
  localparam int DIV_STALLS = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i, we_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i, link_addr_i, inst_i;
  logic [4:0]  waddr_i;
  logic        stallreq_o, valid_o, we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, mem_addr_o, mem_data_o;
  logic [7:0]  aluop_o;
  ex_state_e   fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mdu_stage #(.XLEN(XLEN_TB), .MUL_LAT(MUL_LAT_TB), .RADIX_B(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .flush_i     (flush_i),
    .aluop_i     (aluop_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .waddr_i     (waddr_i),
    .we_i        (we_i),
    .link_addr_i (link_addr_i),
    .inst_i      (inst_i),
    .stallreq_o  (stallreq_o),
    .valid_o     (valid_o),
    .waddr_o     (waddr_o),
    .we_o        (we_o),
    .wdata_o     (wdata_o),
    .aluop_o     (aluop_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .fsm_state   (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single edge; call with stallreq_o low.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] inst);
    aluop_i = op;
    reg1_i  = a;
    reg2_i  = b;
    inst_i  = inst;
    waddr_i = 5'd9;
    we_i    = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    waddr_i = 5'd3;
    we_i    = 1'b0;
  endtask

  task automatic run_single(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, 32'h0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_data"}, wdata_o, exp);
  endtask

  // Multi-cycle op: counts stall cycles, then checks the single result pulse.
  task automatic run_multi(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int stalls;
    int early;
    logic timed_out;
    stalls = 0;
    early = 0;
    timed_out = 1'b1;
    issue(op, a, b, 32'h0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stallreq_o) begin
        timed_out = 1'b0;
        break;
      end
      stalls++;
      if (valid_o || we_o) early++;
    end
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "_early_valid"}, 32'(early), 32'd0);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_data"}, wdata_o, exp);
    check({tag, "_waddr"}, 32'(waddr_o), 32'd9);
    check({tag, "_we"}, 32'(we_o), 32'd1);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    aluop_i = 8'h0;
    reg1_i = '0;
    reg2_i = '0;
    waddr_i = '0;
    we_i = 1'b0;
    link_addr_i = 32'h0000_0400;
    inst_i = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    check("rst_waddr", 32'(waddr_o), 32'(NOP_REG_ADDR));
    check("rst_aluop", 32'(aluop_o), 32'(MEM_NOP_OP));
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_state", 32'(fsm_state), 32'(EX_STATE_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back ADD then SUB
    aluop_i = EXE_ADD_OP; reg1_i = 32'd7; reg2_i = 32'd5; waddr_i = 5'd4; we_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    #1;
    aluop_i = EXE_SUB_OP; reg1_i = 32'd3; reg2_i = 32'd5; waddr_i = 5'd6;
    @(negedge clk);
    check("add_data", wdata_o, 32'd12);
    check("add_waddr", 32'(waddr_o), 32'd4);
    check("add_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("sub_data", wdata_o, 32'hFFFF_FFFE);
    check("sub_waddr", 32'(waddr_o), 32'd6);
    check("sub_stall", 32'(stallreq_o), 32'd0);

    run_single("and", EXE_AND_OP, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    run_single("nor", EXE_NOR_OP, 32'h0, 32'h0, 32'hFFFF_FFFF);
    run_single("xor", EXE_XOR_OP, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5);
    run_single("sll", EXE_SLL_OP, 32'd4, 32'd1, 32'h0000_0010);
    run_single("srl", EXE_SRL_OP, 32'd4, 32'h8000_0000, 32'h0800_0000);
    run_single("sra", EXE_SRA_OP, 32'd4, 32'h8000_0000, 32'hF800_0000);
    run_single("slt", EXE_SLT_OP, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_single("sltu", EXE_SLTU_OP, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_single("jal", EXE_JAL_OP, 32'h0, 32'h0, 32'h0000_0400);

    // Store and load address/data paths
    issue(EXE_SW_OP, 32'h0000_0100, 32'h0000_00AB, 32'h0000_FFFC);
    @(negedge clk);
    check("sw_aluop", 32'(aluop_o), 32'(MEM_SW_OP));
    check("sw_addr", mem_addr_o, 32'h0000_00FC);
    check("sw_data", mem_data_o, 32'h0000_00AB);
    issue(EXE_LW_OP, 32'h0000_0200, 32'h0000_1234, 32'h0000_0008);
    @(negedge clk);
    check("lw_aluop", 32'(aluop_o), 32'(MEM_LW_OP));
    check("lw_addr", mem_addr_o, 32'h0000_0208);
    check("lw_data", mem_data_o, 32'h0);
    @(negedge clk);
    check("idle_aluop", 32'(aluop_o), 32'(MEM_NOP_OP));

    // Multiplier
    run_multi("mulh", EXE_MULH_OP, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MUL_LAT_TB);
    run_multi("mulhu", EXE_MULHU_OP, 32'h8000_0000, 32'd2, 32'h0000_0001, MUL_LAT_TB);
    run_multi("mul", EXE_MUL_OP, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, MUL_LAT_TB);
    run_multi("mul_neg", EXE_MUL_OP, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, MUL_LAT_TB);
    check("mul_aluop", 32'(aluop_o), 32'(MEM_NOP_OP));

`ifdef EX_MDU_DIV_EN
    run_multi("div", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_STALLS);
    run_multi("mod", EXE_MOD_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_STALLS);
    run_multi("divu_zero", EXE_DIVU_OP, 32'd7, 32'd0, 32'hFFFF_FFFF, DIV_STALLS);
    run_multi("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_STALLS);
    run_multi("modu", EXE_MODU_OP, 32'd100, 32'd7, 32'd2, DIV_STALLS);
    issue(EXE_DIV_OP, 32'd100, 32'd3, 32'h0);
    repeat (5) @(negedge clk);
`else
    issue(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'h0);
    @(negedge clk);
    check("nodiv_stall", 32'(stallreq_o), 32'd0);
    check("nodiv_valid", 32'(valid_o), 32'd1);
    check("nodiv_data", wdata_o, 32'h0);
    issue(EXE_MUL_OP, 32'd100, 32'd3, 32'h0);
    @(negedge clk);
`endif

    // Flush mid-operation: nothing written, next op accepted at once
    check("pre_flush_stall", 32'(stallreq_o), 32'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_state", 32'(fsm_state), 32'(EX_STATE_IDLE));
    check("flush_stall", 32'(stallreq_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_we", 32'(we_o), 32'd0);
    run_single("or_after_flush", EXE_OR_OP, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) seen_valid++;
    end
    check("flush_no_late_result", 32'(seen_valid), 32'd0);

    // Asynchronous reset in the middle of a multiply
    issue(EXE_MUL_OP, 32'd6, 32'd7, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_stall", 32'(stallreq_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_wdata", wdata_o, 32'h0);
    check("arst_waddr", 32'(waddr_o), 32'(NOP_REG_ADDR));
    check("arst_state", 32'(fsm_state), 32'(EX_STATE_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_single("add_after_rst", EXE_ADD_OP, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
